// File: rtl/id_stage.sv
// ARM decode stage plus ID/EX register: fields, regfile read addresses, condition check, controls.
// One cycle to the registered outputs; hazard/cond-fail/invalid insert a bubble, flush kills, no upstream stall.
module id_stage #(
  parameter int BIT_NUMBER = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  input  logic [BIT_NUMBER-1:0] pc_in,
  input  logic [31:0]           instruction,
  input  logic [3:0]            status_in,
  input  logic                  hazard,
  input  logic                  flush,
  input  logic [BIT_NUMBER-1:0] reg1,
  input  logic [BIT_NUMBER-1:0] reg2,
  output logic [3:0]            src1,
  output logic [3:0]            src2,
  output logic                  two_src,
  output logic                  has_src1,
  output logic                  valid_out,
  output logic [BIT_NUMBER-1:0] pc_out,
  output logic [BIT_NUMBER-1:0] val_rn,
  output logic [BIT_NUMBER-1:0] val_rm,
  output logic [3:0]            rd_out,
  output logic [3:0]            src1_out,
  output logic [3:0]            src2_out,
  output logic [3:0]            exe_cmd,
  output logic                  wb_en,
  output logic                  mem_r,
  output logic                  mem_w,
  output logic                  b,
  output logic                  s,
  output logic                  imm,
  output logic [11:0]           shift_operand,
  output logic [23:0]           imm24,
  output logic                  carry_out
);

  typedef struct packed {
    logic wb_en;
    logic mem_r;
    logic mem_w;
    logic b;
    logic s;
  } ctrl_t;

  logic [3:0] cond;
  logic [1:0] mode;
  logic       i_bit;
  logic [3:0] opcode;
  logic       s_bit;
  logic [3:0] rn;
  logic [3:0] rd;

  assign cond   = instruction[31:28];
  assign mode   = instruction[27:26];
  assign i_bit  = instruction[25];
  assign opcode = instruction[24:21];
  assign s_bit  = instruction[20];
  assign rn     = instruction[19:16];
  assign rd     = instruction[15:12];

  logic is_str;
  logic is_branch;
  logic is_mov_mvn;

  assign is_str     = (mode == 2'b01) && !s_bit;
  assign is_branch  = (mode == 2'b10);
  assign is_mov_mvn = (mode == 2'b00) && ((opcode == 4'b1101) || (opcode == 4'b1111));

  // STR reads the stored register through the second port, so hazards see it as a source
  assign src1     = instr_valid ? rn : 4'd0;
  assign src2     = !instr_valid ? 4'd0 : (is_str ? rd : instruction[3:0]);
  assign two_src  = instr_valid && (((mode == 2'b00) && !i_bit) || is_str);
  assign has_src1 = instr_valid && !is_mov_mvn && !is_branch;

  ctrl_t      ctrl;
  logic [3:0] cmd;

  always_comb begin
    ctrl = '0;
    cmd  = 4'b0000;
    case (mode)
      2'b00: begin
        ctrl.wb_en = 1'b1;
        ctrl.s     = s_bit;
        case (opcode)
          4'b1101: cmd = 4'b0001;
          4'b1111: cmd = 4'b1001;
          4'b0100: cmd = 4'b0010;
          4'b0101: cmd = 4'b0011;
          4'b0010: cmd = 4'b0100;
          4'b0110: cmd = 4'b0101;
          4'b0000: cmd = 4'b0110;
          4'b1100: cmd = 4'b0111;
          4'b0001: cmd = 4'b1000;
          4'b1010: begin
            cmd        = 4'b0100;
            ctrl.wb_en = 1'b0;
            ctrl.s     = 1'b1;
          end
          4'b1000: begin
            cmd        = 4'b0110;
            ctrl.wb_en = 1'b0;
            ctrl.s     = 1'b1;
          end
          default: begin
            cmd  = 4'b0000;
            ctrl = '0;
          end
        endcase
      end
      2'b01: begin
        cmd = 4'b0010;
        if (s_bit) begin
          ctrl.mem_r = 1'b1;
          ctrl.wb_en = 1'b1;
        end else begin
          ctrl.mem_w = 1'b1;
        end
      end
      2'b10: ctrl.b = 1'b1;
      default: begin
        cmd  = 4'b0000;
        ctrl = '0;
      end
    endcase
  end

  logic flag_n;
  logic flag_z;
  logic flag_c;
  logic flag_v;
  logic cond_pass;

  assign {flag_n, flag_z, flag_c, flag_v} = status_in;

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = !flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = !flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = !flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = !flag_v;
      4'b1000: cond_pass = flag_c && !flag_z;
      4'b1001: cond_pass = !flag_c || flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
      4'b1101: cond_pass = flag_z || (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  logic bubble;
  assign bubble = hazard || !cond_pass || !instr_valid;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_out     <= 1'b0;
      pc_out        <= '0;
      val_rn        <= '0;
      val_rm        <= '0;
      rd_out        <= 4'd0;
      src1_out      <= 4'd0;
      src2_out      <= 4'd0;
      exe_cmd       <= 4'd0;
      wb_en         <= 1'b0;
      mem_r         <= 1'b0;
      mem_w         <= 1'b0;
      b             <= 1'b0;
      s             <= 1'b0;
      imm           <= 1'b0;
      shift_operand <= 12'd0;
      imm24         <= 24'd0;
      carry_out     <= 1'b0;
    end else begin
      // datapath loads even on a bubble; only the side-effecting controls are suppressed
      pc_out        <= pc_in;
      val_rn        <= reg1;
      val_rm        <= reg2;
      rd_out        <= rd;
      src1_out      <= src1;
      src2_out      <= src2;
      exe_cmd       <= cmd;
      imm           <= i_bit;
      shift_operand <= instruction[11:0];
      imm24         <= instruction[23:0];
      carry_out     <= flag_c;
      if (bubble) begin
        valid_out <= 1'b0;
        wb_en     <= 1'b0;
        mem_r     <= 1'b0;
        mem_w     <= 1'b0;
        b         <= 1'b0;
        s         <= 1'b0;
      end else begin
        valid_out <= 1'b1;
        wb_en     <= ctrl.wb_en;
        mem_r     <= ctrl.mem_r;
        mem_w     <= ctrl.mem_w;
        b         <= ctrl.b;
        s         <= ctrl.s;
      end
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: expected EX-side values are queued when a vector is driven and checked after the edge.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] pc_in = '0;
  logic [31:0] instruction = '0;
  logic [3:0]  status_in = '0;
  logic        hazard = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] reg1 = '0;
  logic [31:0] reg2 = '0;
  logic [3:0]  src1, src2, rd_out, src1_out, src2_out, exe_cmd;
  logic        two_src, has_src1, valid_out, wb_en, mem_r, mem_w, b, s, imm, carry_out;
  logic [31:0] pc_out, val_rn, val_rm;
  logic [11:0] shift_operand;
  logic [23:0] imm24;

  id_stage #(.BIT_NUMBER(32)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .pc_in(pc_in),
    .instruction(instruction), .status_in(status_in), .hazard(hazard), .flush(flush),
    .reg1(reg1), .reg2(reg2), .src1(src1), .src2(src2), .two_src(two_src),
    .has_src1(has_src1), .valid_out(valid_out), .pc_out(pc_out), .val_rn(val_rn),
    .val_rm(val_rm), .rd_out(rd_out), .src1_out(src1_out), .src2_out(src2_out),
    .exe_cmd(exe_cmd), .wb_en(wb_en), .mem_r(mem_r), .mem_w(mem_w), .b(b), .s(s),
    .imm(imm), .shift_operand(shift_operand), .imm24(imm24), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r, v, h, f;
    logic [31:0] ins;
    logic [3:0]  st;
    logic [31:0] r1, r2;
    logic        ev;
    logic [3:0]  exe;
    logic [4:0]  ctl;   // {wb_en, mem_r, mem_w, b, s} assuming the instruction issues
    logic [3:0]  s1, s2;
    logic        two, has1;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [31:0] pc, rn, rm;
    logic [3:0]  rd, s1, s2, exe;
    logic [4:0]  ctl;
    logic        imm, carry;
    logic [11:0] shop;
    logic [23:0] i24;
  } exp_t;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];
  vec_t vecs[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic vec_t mk(logic r, logic v, logic h, logic f, logic [31:0] ins, logic [3:0] st,
                              logic [31:0] r1, logic [31:0] r2, logic ev, logic [3:0] exe,
                              logic [4:0] ctl, logic [3:0] s1, logic [3:0] s2, logic two, logic has1);
    vec_t x;
    x.r = r; x.v = v; x.h = h; x.f = f; x.ins = ins; x.st = st; x.r1 = r1; x.r2 = r2;
    x.ev = ev; x.exe = exe; x.ctl = ctl; x.s1 = s1; x.s2 = s2; x.two = two; x.has1 = has1;
    return x;
  endfunction

  initial begin
    exp_t e;
    exp_t got;
    vec_t x;
    //                 r  v  h  f  instr         st     reg1   reg2  ev exe      ctl       s1 s2 two has1
    vecs.push_back(mk(1, 0, 0, 0, 32'hE0821003, 4'h0, 5,     7,    0, 4'b0000, 5'b00000, 0, 0, 0, 0)); // reset
    vecs.push_back(mk(0, 1, 0, 0, 32'hE0821003, 4'h0, 5,     7,    1, 4'b0010, 5'b10000, 2, 3, 1, 1)); // ADD
    vecs.push_back(mk(0, 1, 0, 0, 32'h03A00001, 4'h0, 9,     9,    0, 4'b0001, 5'b10000, 0, 1, 0, 0)); // MOVEQ Z=0
    vecs.push_back(mk(0, 1, 0, 0, 32'h03A00001, 4'h4, 9,     9,    1, 4'b0001, 5'b10000, 0, 1, 0, 0)); // MOVEQ Z=1
    vecs.push_back(mk(0, 1, 0, 0, 32'hE5854000, 4'h0, 'h50, 'h40,  1, 4'b0010, 5'b00100, 5, 4, 1, 1)); // STR
    vecs.push_back(mk(0, 1, 0, 0, 32'hE5954000, 4'h0, 'h50, 'h40,  1, 4'b0010, 5'b11000, 5, 0, 0, 1)); // LDR
    vecs.push_back(mk(0, 1, 1, 1, 32'hE0821003, 4'h0, 5,     7,    0, 4'b0010, 5'b10000, 2, 3, 1, 1)); // hazard+flush
    vecs.push_back(mk(0, 1, 1, 0, 32'hE0821003, 4'h0, 11,    12,   0, 4'b0010, 5'b10000, 2, 3, 1, 1)); // hazard
    vecs.push_back(mk(0, 1, 0, 0, 32'hE1510002, 4'h0, 3,     4,    1, 4'b0100, 5'b00001, 1, 2, 1, 1)); // CMP
    vecs.push_back(mk(0, 1, 0, 0, 32'hEAFFFFFE, 4'h0, 0,     0,    1, 4'b0000, 5'b00010, 15, 14, 0, 0)); // B
    vecs.push_back(mk(0, 0, 0, 0, 32'hE0821003, 4'h0, 1,     2,    0, 4'b0010, 5'b10000, 0, 0, 0, 0)); // invalid
    vecs.push_back(mk(0, 1, 0, 0, 32'hF0821003, 4'h0, 1,     2,    0, 4'b0010, 5'b10000, 2, 3, 1, 1)); // cond 1111
    vecs.push_back(mk(0, 1, 0, 0, 32'hC0921003, 4'h9, 1,     2,    1, 4'b0010, 5'b10001, 2, 3, 1, 1)); // ADDSGT pass
    vecs.push_back(mk(0, 1, 0, 0, 32'hC0921003, 4'h8, 1,     2,    0, 4'b0010, 5'b10001, 2, 3, 1, 1)); // ADDSGT fail
    vecs.push_back(mk(0, 1, 0, 0, 32'hE0C21003, 4'h2, 1,     2,    1, 4'b0101, 5'b10000, 2, 3, 1, 1)); // SBC, C=1
    vecs.push_back(mk(0, 1, 0, 0, 32'hE0A21003, 4'h0, 1,     2,    1, 4'b0011, 5'b10000, 2, 3, 1, 1)); // ADC
    vecs.push_back(mk(0, 1, 0, 0, 32'hE0421003, 4'h0, 1,     2,    1, 4'b0100, 5'b10000, 2, 3, 1, 1)); // SUB
    vecs.push_back(mk(0, 1, 0, 0, 32'hE0021003, 4'h0, 1,     2,    1, 4'b0110, 5'b10000, 2, 3, 1, 1)); // AND
    vecs.push_back(mk(0, 1, 0, 0, 32'hE1821003, 4'h0, 1,     2,    1, 4'b0111, 5'b10000, 2, 3, 1, 1)); // ORR
    vecs.push_back(mk(0, 1, 0, 0, 32'hE0221003, 4'h0, 1,     2,    1, 4'b1000, 5'b10000, 2, 3, 1, 1)); // EOR
    vecs.push_back(mk(0, 1, 0, 0, 32'hE1120003, 4'h0, 1,     2,    1, 4'b0110, 5'b00001, 2, 3, 1, 1)); // TST
    vecs.push_back(mk(0, 1, 0, 0, 32'hE1E00003, 4'h0, 1,     2,    1, 4'b1001, 5'b10000, 0, 3, 1, 0)); // MVN
    vecs.push_back(mk(0, 1, 0, 0, 32'hE1621003, 4'h0, 1,     2,    1, 4'b0000, 5'b00000, 2, 3, 1, 1)); // unlisted opcode
    vecs.push_back(mk(0, 1, 0, 0, 32'hEE000000, 4'h0, 1,     2,    1, 4'b0000, 5'b00000, 0, 0, 0, 1)); // mode 11
    vecs.push_back(mk(0, 1, 0, 0, 32'h80821003, 4'h2, 6,     8,    1, 4'b0010, 5'b10000, 2, 3, 1, 1)); // HI pass
    vecs.push_back(mk(0, 1, 0, 0, 32'hB0821003, 4'h9, 6,     8,    0, 4'b0010, 5'b10000, 2, 3, 1, 1)); // LT fail
    vecs.push_back(mk(1, 1, 0, 0, 32'hE0821003, 4'h0, 6,     8,    0, 4'b0010, 5'b10000, 2, 3, 1, 1)); // reset mid-stream
    vecs.push_back(mk(0, 1, 0, 0, 32'hE0821003, 4'h0, 6,     8,    1, 4'b0010, 5'b10000, 2, 3, 1, 1)); // ADD after reset
    vecs.push_back(mk(0, 1, 0, 1, 32'hE5954000, 4'hF, 6,     8,    0, 4'b0010, 5'b11000, 5, 0, 0, 1)); // flush alone

    foreach (vecs[i]) begin
      x = vecs[i];
      @(negedge clk);
      rst = x.r; instr_valid = x.v; hazard = x.h; flush = x.f;
      instruction = x.ins; status_in = x.st; reg1 = x.r1; reg2 = x.r2;
      pc_in = 32'h1000 + 32'(i) * 4;
      #1;
      chk($sformatf("v%0d.src1", i), 32'(src1), 32'(x.s1));
      chk($sformatf("v%0d.src2", i), 32'(src2), 32'(x.s2));
      chk($sformatf("v%0d.two_src", i), 32'(two_src), 32'(x.two));
      chk($sformatf("v%0d.has_src1", i), 32'(has_src1), 32'(x.has1));

      if (x.r || x.f) begin
        e = '{valid: 0, pc: 0, rn: 0, rm: 0, rd: 0, s1: 0, s2: 0, exe: 0, ctl: 0,
              imm: 0, carry: 0, shop: 0, i24: 0};
      end else begin
        e.valid = x.ev;
        e.pc    = pc_in;
        e.rn    = x.r1;
        e.rm    = x.r2;
        e.rd    = x.ins[15:12];
        e.s1    = x.s1;
        e.s2    = x.s2;
        e.exe   = x.exe;
        e.ctl   = x.ev ? x.ctl : 5'b00000;
        e.imm   = x.ins[25];
        e.carry = x.st[1];
        e.shop  = x.ins[11:0];
        e.i24   = x.ins[23:0];
      end
      sb.push_back(e);

      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        chk($sformatf("v%0d.scoreboard_empty", i), 32'd1, 32'd0);
      end else begin
        got = sb.pop_front();
        chk($sformatf("v%0d.valid_out", i), 32'(valid_out), 32'(got.valid));
        chk($sformatf("v%0d.pc_out", i), pc_out, got.pc);
        chk($sformatf("v%0d.val_rn", i), val_rn, got.rn);
        chk($sformatf("v%0d.val_rm", i), val_rm, got.rm);
        chk($sformatf("v%0d.rd_out", i), 32'(rd_out), 32'(got.rd));
        chk($sformatf("v%0d.src1_out", i), 32'(src1_out), 32'(got.s1));
        chk($sformatf("v%0d.src2_out", i), 32'(src2_out), 32'(got.s2));
        chk($sformatf("v%0d.exe_cmd", i), 32'(exe_cmd), 32'(got.exe));
        chk($sformatf("v%0d.wb_en", i), 32'(wb_en), 32'(got.ctl[4]));
        chk($sformatf("v%0d.mem_r", i), 32'(mem_r), 32'(got.ctl[3]));
        chk($sformatf("v%0d.mem_w", i), 32'(mem_w), 32'(got.ctl[2]));
        chk($sformatf("v%0d.b", i), 32'(b), 32'(got.ctl[1]));
        chk($sformatf("v%0d.s", i), 32'(s), 32'(got.ctl[0]));
        chk($sformatf("v%0d.imm", i), 32'(imm), 32'(got.imm));
        chk($sformatf("v%0d.carry_out", i), 32'(carry_out), 32'(got.carry));
        chk($sformatf("v%0d.shift_operand", i), 32'(shift_operand), 32'(got.shop));
        chk($sformatf("v%0d.imm24", i), 32'(imm24), 32'(got.i24));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
